// File: rtl/shiftrl_seq.sv
// shiftrl_seq: multi-cycle right shifter (SRL, optionally SRA) for the ALU path.
// Shifts a 32-bit operand by sel[4:0], at most STEP bits per clock, with a
// start/busy/done handshake and z/n/c/o flags for the final result.
// Optional feature macro: SHIFTRL_SEQ_ARITH_EN enables sign fill when arith=1;
// without it the arith input is ignored and every shift is logical.
module shiftrl_seq #(
    parameter int STEP = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] busA,
    input  logic [31:0] sel,
    input  logic        arith,
    output logic [31:0] busSRL,
    output logic        zSRL,
    output logic        nSRL,
    output logic        cSRL,
    output logic        oSRL,
    output logic        busy,
    output logic        done
);

    localparam int         DATA_W   = 32;
    localparam logic [4:0] STEP_AMT = 5'(STEP);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state, stateNext;

    // Working registers for the operation in flight.
    logic [DATA_W-1:0] acc, accNext;
    logic [4:0]        rem, remNext;
    logic              fill, fillNext;
    logic              carry, carryNext;
    logic              sticky, stickyNext;

    // Next values for the visible result/flag registers.
    logic [DATA_W-1:0] busSRLNext;
    logic              zNext, nNext, cNext, oNext;
    logic              busyNext, doneNext;

    // Per-cycle shift network outputs.
    logic [4:0]        shiftAmt;
    logic [DATA_W-1:0] shifted;
    logic              stepCarry;
    logic              stepLost;
    logic              captureFill;

    // sel[31:5] never matters; arith is unused when sign fill is compiled out.
    logic unusedBits;
    assign unusedBits = ^{sel[31:5], arith};

    // Bits to shift this cycle: whatever remains, capped at STEP.
    function automatic logic [4:0] stepAmount(input logic [4:0] remaining);
        return (remaining < STEP_AMT) ? remaining : STEP_AMT;
    endfunction

    // Right shift with the vacated top bits set to f (invert trick gives 1-fill).
    function automatic logic [DATA_W-1:0] shiftFill(input logic [DATA_W-1:0] val,
                                                    input logic [4:0]        amt,
                                                    input logic              f);
        return f ? ~((~val) >> amt) : (val >> amt);
    endfunction

    // OR of the bits that fall off the bottom during this step.
    function automatic logic lostBits(input logic [DATA_W-1:0] val,
                                      input logic [4:0]        amt);
        return |(val & ~({DATA_W{1'b1}} << amt));
    endfunction

    // Last bit shifted out this step; a zero-length step keeps the old carry.
    function automatic logic lastOut(input logic [DATA_W-1:0] val,
                                     input logic [4:0]        amt,
                                     input logic              prev);
        return (amt != 5'd0) ? val[amt - 5'd1] : prev;
    endfunction

`ifdef SHIFTRL_SEQ_ARITH_EN
    assign captureFill = arith & busA[31];
`else
    assign captureFill = 1'b0;
`endif

    assign shiftAmt  = stepAmount(rem);
    assign shifted   = shiftFill(acc, shiftAmt, fill);
    assign stepCarry = lastOut(acc, shiftAmt, carry);
    assign stepLost  = lostBits(acc, shiftAmt);

    // State and datapath registers; async reset clears everything and aborts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            rem    <= '0;
            fill   <= 1'b0;
            carry  <= 1'b0;
            sticky <= 1'b0;
            busSRL <= '0;
            zSRL   <= 1'b0;
            nSRL   <= 1'b0;
            cSRL   <= 1'b0;
            oSRL   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= stateNext;
            acc    <= accNext;
            rem    <= remNext;
            fill   <= fillNext;
            carry  <= carryNext;
            sticky <= stickyNext;
            busSRL <= busSRLNext;
            zSRL   <= zNext;
            nSRL   <= nNext;
            cSRL   <= cNext;
            oSRL   <= oNext;
            busy   <= busyNext;
            done   <= doneNext;
        end
    end

    // Next-state logic: accept in IDLE, step in SHIFT, publish on the last step.
    always_comb begin
        stateNext  = state;
        accNext    = acc;
        remNext    = rem;
        fillNext   = fill;
        carryNext  = carry;
        stickyNext = sticky;
        busSRLNext = busSRL;
        zNext      = zSRL;
        nNext      = nSRL;
        cNext      = cSRL;
        oNext      = oSRL;
        busyNext   = busy;
        doneNext   = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    accNext    = busA;
                    remNext    = sel[4:0];
                    fillNext   = captureFill;
                    carryNext  = 1'b0;
                    stickyNext = 1'b0;
                    busyNext   = 1'b1;
                    stateNext  = SHIFT;
                end
            end
            SHIFT: begin
                accNext    = shifted;
                remNext    = rem - shiftAmt;
                carryNext  = stepCarry;
                stickyNext = sticky | stepLost;
                // Last step (also covers a zero-length shift on entry).
                if (rem == shiftAmt) begin
                    busSRLNext = shifted;
                    zNext      = ~|shifted;
                    nNext      = shifted[DATA_W-1];
                    cNext      = stepCarry;
                    oNext      = sticky | stepLost;
                    doneNext   = 1'b1;
                    busyNext   = 1'b0;
                    stateNext  = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
                busyNext  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_shiftrl_seq.sv
// tb_shiftrl_seq: directed self-checking bench for shiftrl_seq (STEP=7).
// Expected sign-fill results follow SHIFTRL_SEQ_ARITH_EN as compiled.
module tb_shiftrl_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] busA;
    logic [31:0] sel;
    logic        arith;
    logic [31:0] busSRL;
    logic        zSRL, nSRL, cSRL, oSRL;
    logic        busy, done;

    int nChecks = 0;
    int nFails  = 0;

    shiftrl_seq #(.STEP(7)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .busA   (busA),
        .sel    (sel),
        .arith  (arith),
        .busSRL (busSRL),
        .zSRL   (zSRL),
        .nSRL   (nSRL),
        .cSRL   (cSRL),
        .oSRL   (oSRL),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Issue one request at posedge+1, scramble inputs after capture, wait for done.
    task automatic runOp(input logic [31:0] a, input logic [31:0] s,
                         input logic ar, output int lat);
        busA  = a;
        sel   = s;
        arith = ar;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busA  = ~a;
        sel   = 32'h0000_001F;
        arith = ~ar;
        lat   = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; busA = '0; sel = '0; arith = 1'b0;
        #3;
        nChecks++;
        if ({busSRL, zSRL, nSRL, cSRL, oSRL, busy, done} !== 38'd0) begin
            nFails++;
            $display("FAIL reset_state: got %h expected 0",
                     {busSRL, zSRL, nSRL, cSRL, oSRL, busy, done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        nChecks++;
        if ({busy, done} !== 2'b00) begin
            nFails++;
            $display("FAIL idle_after_reset: got busy/done %b expected 00", {busy, done});
        end
    endtask

    task automatic test_zero_shift;
        int lat;
        runOp(32'h8000_0001, 32'd0, 1'b0, lat);
        nChecks++;
        if (lat !== 1) begin
            nFails++;
            $display("FAIL zero_latency: got %0d expected 1", lat);
        end
        nChecks++;
        if ({busSRL, zSRL, nSRL, cSRL, oSRL} !== {32'h8000_0001, 4'b0100}) begin
            nFails++;
            $display("FAIL zero_result: got %h expected %h",
                     {busSRL, zSRL, nSRL, cSRL, oSRL}, {32'h8000_0001, 4'b0100});
        end
        // sel=32 has sel[4:0]=0, so it is a zero shift too.
        runOp(32'h0000_0003, 32'd32, 1'b0, lat);
        nChecks++;
        if (lat !== 1) begin
            nFails++;
            $display("FAIL sel32_latency: got %0d expected 1", lat);
        end
        nChecks++;
        if ({busSRL, zSRL, nSRL, cSRL, oSRL} !== {32'h0000_0003, 4'b0000}) begin
            nFails++;
            $display("FAIL sel32_result: got %h expected %h",
                     {busSRL, zSRL, nSRL, cSRL, oSRL}, {32'h0000_0003, 4'b0000});
        end
    endtask

    task automatic test_max_logical;
        busA = 32'hF000_0000; sel = 32'd31; arith = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; busA = 32'h0; sel = 32'h0;
        for (int k = 1; k <= 5; k++) begin
            nChecks++;
            if ({busy, done} !== 2'b10) begin
                nFails++;
                $display("FAIL max_busy_cycle%0d: got busy/done %b expected 10", k, {busy, done});
            end
            @(posedge clk); #1;
        end
        nChecks++;
        if ({busy, done} !== 2'b01) begin
            nFails++;
            $display("FAIL max_done_edge5: got busy/done %b expected 01", {busy, done});
        end
        nChecks++;
        if ({busSRL, zSRL, nSRL, cSRL, oSRL} !== {32'h0000_0001, 4'b0011}) begin
            nFails++;
            $display("FAIL max_result: got %h expected %h",
                     {busSRL, zSRL, nSRL, cSRL, oSRL}, {32'h0000_0001, 4'b0011});
        end
        @(posedge clk); #1;
        nChecks++;
        if ({done, busSRL, zSRL, nSRL, cSRL, oSRL} !== {1'b0, 32'h0000_0001, 4'b0011}) begin
            nFails++;
            $display("FAIL max_hold: got %h expected %h",
                     {done, busSRL, zSRL, nSRL, cSRL, oSRL}, {1'b0, 32'h0000_0001, 4'b0011});
        end
    endtask

    task automatic test_sticky_carry;
        int lat;
        runOp(32'h0000_0005, 32'd2, 1'b0, lat);
        nChecks++;
        if ({lat == 1, busSRL, zSRL, nSRL, cSRL, oSRL} !== {1'b1, 32'h0000_0001, 4'b0001}) begin
            nFails++;
            $display("FAIL split_5_by_2: got lat %0d res %h expected lat 1 res %h",
                     lat, {busSRL, zSRL, nSRL, cSRL, oSRL}, {32'h0000_0001, 4'b0001});
        end
        runOp(32'h0000_0004, 32'd3, 1'b0, lat);
        nChecks++;
        if ({lat == 1, busSRL, zSRL, nSRL, cSRL, oSRL} !== {1'b1, 32'h0000_0000, 4'b1011}) begin
            nFails++;
            $display("FAIL split_4_by_3: got lat %0d res %h expected lat 1 res %h",
                     lat, {busSRL, zSRL, nSRL, cSRL, oSRL}, {32'h0000_0000, 4'b1011});
        end
    endtask

    task automatic test_arith;
        int lat;
        logic [35:0] exp8, exp31;
`ifdef SHIFTRL_SEQ_ARITH_EN
        exp8  = {32'hFF80_0000, 4'b0100};
        exp31 = {32'hFFFF_FFFF, 4'b0100};
`else
        exp8  = {32'h0080_0000, 4'b0000};
        exp31 = {32'h0000_0001, 4'b0000};
`endif
        runOp(32'h8000_0000, 32'd8, 1'b1, lat);
        nChecks++;
        if (lat !== 2) begin
            nFails++;
            $display("FAIL arith8_latency: got %0d expected 2", lat);
        end
        nChecks++;
        if ({busSRL, zSRL, nSRL, cSRL, oSRL} !== exp8) begin
            nFails++;
            $display("FAIL arith8_result: got %h expected %h",
                     {busSRL, zSRL, nSRL, cSRL, oSRL}, exp8);
        end
        runOp(32'h8000_0000, 32'd31, 1'b1, lat);
        nChecks++;
        if ({lat == 5, busSRL, zSRL, nSRL, cSRL, oSRL} !== {1'b1, exp31}) begin
            nFails++;
            $display("FAIL arith31: got lat %0d res %h expected lat 5 res %h",
                     lat, {busSRL, zSRL, nSRL, cSRL, oSRL}, exp31);
        end
        runOp(32'h4000_0000, 32'd8, 1'b1, lat);
        nChecks++;
        if ({lat == 2, busSRL, zSRL, nSRL, cSRL, oSRL} !== {1'b1, 32'h0040_0000, 4'b0000}) begin
            nFails++;
            $display("FAIL arith_positive: got lat %0d res %h expected lat 2 res %h",
                     lat, {busSRL, zSRL, nSRL, cSRL, oSRL}, {32'h0040_0000, 4'b0000});
        end
    endtask

    task automatic test_back_to_back;
        busA = 32'h0000_0E00; sel = 32'd10; arith = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        // Second request while busy, with different data: must be ignored.
        busA = 32'hFFFF_FFFF; sel = 32'd1; start = 1'b1;
        nChecks++;
        if (busy !== 1'b1) begin
            nFails++;
            $display("FAIL hs_busy_after_start: got %b expected 1", busy);
        end
        @(posedge clk); #1;
        start = 1'b0;
        nChecks++;
        if ({busy, done} !== 2'b10) begin
            nFails++;
            $display("FAIL hs_ignored_start: got busy/done %b expected 10", {busy, done});
        end
        @(posedge clk); #1;
        nChecks++;
        if ({done, busSRL, zSRL, nSRL, cSRL, oSRL} !== {1'b1, 32'h0000_0003, 4'b0011}) begin
            nFails++;
            $display("FAIL hs_first_result: got %h expected %h",
                     {done, busSRL, zSRL, nSRL, cSRL, oSRL}, {1'b1, 32'h0000_0003, 4'b0011});
        end
        // Start in the done cycle is accepted.
        busA = 32'h8000_0000; sel = 32'd1; arith = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; busA = 32'h0; sel = 32'h0;
        nChecks++;
        if ({busy, done, busSRL} !== {2'b10, 32'h0000_0003}) begin
            nFails++;
            $display("FAIL hs_accept_in_done: got %h expected %h",
                     {busy, done, busSRL}, {2'b10, 32'h0000_0003});
        end
        @(posedge clk); #1;
        nChecks++;
        if ({done, busSRL, zSRL, nSRL, cSRL, oSRL} !== {1'b1, 32'h4000_0000, 4'b0000}) begin
            nFails++;
            $display("FAIL hs_second_result: got %h expected %h",
                     {done, busSRL, zSRL, nSRL, cSRL, oSRL}, {1'b1, 32'h4000_0000, 4'b0000});
        end
        @(posedge clk); #1;
        nChecks++;
        if ({busy, done, busSRL} !== {2'b00, 32'h4000_0000}) begin
            nFails++;
            $display("FAIL hs_settle: got %h expected %h",
                     {busy, done, busSRL}, {2'b00, 32'h4000_0000});
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        busA = 32'hFFFF_FFFF; sel = 32'd31; arith = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        #2;
        rst_n = 1'b0;
        #1;
        nChecks++;
        if ({busSRL, zSRL, nSRL, cSRL, oSRL, busy, done} !== 38'd0) begin
            nFails++;
            $display("FAIL reset_mid_clear: got %h expected 0",
                     {busSRL, zSRL, nSRL, cSRL, oSRL, busy, done});
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            nChecks++;
            if ({busy, done} !== 2'b00) begin
                nFails++;
                $display("FAIL reset_mid_hold%0d: got busy/done %b expected 00", k, {busy, done});
            end
        end
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            nChecks++;
            if (done !== 1'b0) begin
                nFails++;
                $display("FAIL reset_mid_no_done%0d: got %b expected 0", k, done);
            end
        end
        runOp(32'h1234_5678, 32'd4, 1'b0, lat);
        nChecks++;
        if ({lat == 1, busSRL, zSRL, nSRL, cSRL, oSRL} !== {1'b1, 32'h0123_4567, 4'b0011}) begin
            nFails++;
            $display("FAIL reset_mid_restart: got lat %0d res %h expected lat 1 res %h",
                     lat, {busSRL, zSRL, nSRL, cSRL, oSRL}, {32'h0123_4567, 4'b0011});
        end
    endtask

    initial begin
        test_reset();
        test_zero_shift();
        test_max_logical();
        test_sticky_carry();
        test_arith();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
